axis_pattern_checker: RTL and testbench

- Receive-side consumer sitting directly on the converter's m_axis output (LBUS->AXIS), on the same bus clock.
- Checks every beat against a deterministic per-packet byte pattern, validates tkeep framing, and counts packets, bytes and errors.
- Issues a single pass/fail verdict after the expected packet count, or after an idle timeout once the remote sender reports done.
- The stream has no tready; the checker never applies backpressure and must accept a beat on every cycle.

---
 rtl/axis_pattern_checker.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_axis_pattern_checker.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_checker.sv
// axis_pattern_checker
//   Receive-side checker on an AXI-Stream (no tready). Every beat is compared
//   against a deterministic per-packet byte pattern. The pattern byte for lane L
//   is (pkt_idx + byte_off + L) mod 256. The checker also validates tkeep
//   framing and counts packets, bytes and errored packets. A single pass/fail
//   verdict is issued after NUM_PKTS packets, or after an idle timeout once the
//   sender reports done.
//
//   Pipeline:
//     S1 registers the beat together with its pattern base.
//     S2 registers beat_err, built from the per-lane compares and the keep check.
//     S3 registers the popcount of tkeep.
//     The counters are updated from S3, 3 cycles after the beat is sampled.
//
//   Ports:
//     rx_clk, rst            bus clock; synchronous active-high reset
//     s_axis_t{data,keep,last,valid}  input stream, byte 0 at tdata[7:0]
//     remote_send_done       level, sender finished
//     pkt_cnt, err_cnt       32-bit saturating packet / errored-packet counts
//     byte_cnt               48-bit wrapping valid-byte count
//     check_result(_valid)   verdict, sticky until rst
//
//   Optional: define AXIS_CHECKER_ERR_CAPTURE_EN to add the first_err_pkt,
//   first_err_beat and first_err_valid outputs. These capture where the first
//   error occurred.

module axis_pattern_checker_lane (
  input  logic [7:0] data,
  input  logic [7:0] exp_byte,
  input  logic       keep,
  output logic       mis
);
  assign mis = keep && (data != exp_byte);
endmodule

module axis_pattern_checker #(
  parameter int DWIDTH       = 512,
  parameter int NUM_PKTS     = 1024,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                  rx_clk,
  input  logic                  rst,
  input  logic [DWIDTH-1:0]     s_axis_tdata,
  input  logic [DWIDTH/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  input  logic                  remote_send_done,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           err_cnt,
  output logic [47:0]           byte_cnt,
  output logic                  check_result,
  output logic                  check_result_valid
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
  ,
  output logic [31:0]           first_err_pkt,
  output logic [15:0]           first_err_beat,
  output logic [0:0]            first_err_valid
`endif
);
  localparam int KW  = DWIDTH / 8;
  localparam int PCW = $clog2(KW + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state_q, state_d;

  // input-side packet tracking
  logic        accept;
  logic [31:0] pkt_idx_q, pkt_idx_d;
  logic [7:0]  byte_off_q, byte_off_d;

  // stage valids: [0]=S1, [1]=S2, [2]=S3
  logic [2:0]  vld_q;

  logic [DWIDTH-1:0] s1_data_q;
  logic [KW-1:0]     s1_keep_q;
  logic              s1_last_q;
  logic [7:0]        s1_base_q;

  logic [KW-1:0]     lane_mis;
  logic              keep_ok, beat_err;

  logic              s2_err_q, s2_last_q;
  logic [KW-1:0]     s2_keep_q;
  logic [PCW-1:0]    s2_pop;

  logic              s3_err_q, s3_last_q;
  logic [PCW-1:0]    s3_bytes_q;

  logic [31:0] pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [47:0] byte_cnt_q, byte_cnt_d;
  logic        pkt_err_q, pkt_err_d, mid_pkt_q, mid_pkt_d;
  logic        part_err_q, part_err_d;
  logic        res_q, res_d, resv_q, resv_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic        upd, pkt_err_now, last_done, idle_run, timeout;

`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
  logic [15:0] beat_idx_q, beat_idx_d;
  logic [31:0] s1_pkt_q, s2_pkt_q, s3_pkt_q;
  logic [15:0] s1_beat_q, s2_beat_q, s3_beat_q;
  logic [31:0] fe_pkt_q, fe_pkt_d;
  logic [15:0] fe_beat_q, fe_beat_d;
  logic        fe_vld_q, fe_vld_d;
`endif

  // ---------------- input sampling ----------------
  // Beats in DONE are dropped here, so nothing downstream ever sees them.
  assign accept = s_axis_tvalid && (state_q != ST_DONE);

  always_comb begin
    pkt_idx_d  = pkt_idx_q;
    byte_off_d = byte_off_q;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
    beat_idx_d = beat_idx_q;
`endif
    if (accept) begin
      if (s_axis_tlast) begin
        pkt_idx_d  = pkt_idx_q + 32'd1;
        byte_off_d = '0;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
        beat_idx_d = '0;
`endif
      end else begin
        byte_off_d = byte_off_q + 8'(KW);
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
        beat_idx_d = beat_idx_q + 16'd1;
`endif
      end
    end
  end

  // ---------------- S2: per-lane compare and framing ----------------
  for (genvar gl = 0; gl < KW; gl++) begin : g_lane
    axis_pattern_checker_lane u_lane (
      .data     (s1_data_q[gl*8 +: 8]),
      .exp_byte (s1_base_q + 8'(gl)),
      .keep     (s1_keep_q[gl]),
      .mis      (lane_mis[gl])
    );
  end

  // Last beat: keep must be 2^n-1 (nonzero, and keep & (keep+1) == 0).
  // Other beats: keep must be all ones.
  always_comb begin
    if (s1_last_q)
      keep_ok = (s1_keep_q != '0) && ((s1_keep_q & (s1_keep_q + KW'(1))) == '0);
    else
      keep_ok = (s1_keep_q == '1);
    beat_err = (|lane_mis) || !keep_ok;
  end

  always_comb begin
    s2_pop = '0;
    for (int i = 0; i < KW; i++) s2_pop = s2_pop + PCW'(s2_keep_q[i]);
  end

  // ---------------- S3 accumulate, idle timer, FSM ----------------
  assign upd         = vld_q[2] && (state_q != ST_DONE);
  assign pkt_err_now = pkt_err_q | s3_err_q;
  assign last_done   = upd && s3_last_q && (pkt_cnt_q == 32'(NUM_PKTS - 1));
  assign idle_run    = remote_send_done && !s_axis_tvalid && (vld_q == '0);
  // Fires on the edge at which the idle count reaches IDLE_TIMEOUT.
  assign timeout     = idle_run && (state_q != ST_DONE) &&
                       (({16'd0, idle_cnt_q} + 32'd1) >= 32'(IDLE_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pkt_err_d  = pkt_err_q;
    mid_pkt_d  = mid_pkt_q;
    part_err_d = part_err_q;
    res_d      = res_q;
    resv_d     = resv_q;
    idle_cnt_d = idle_cnt_q;

    if (s_axis_tvalid)                         idle_cnt_d = '0;
    else if (idle_run && (idle_cnt_q != '1))   idle_cnt_d = idle_cnt_q + 16'd1;

    if (upd) begin
      byte_cnt_d = byte_cnt_q + 48'(s3_bytes_q);
      if (s3_last_q) begin
        if (pkt_cnt_q != '1)                 pkt_cnt_d = pkt_cnt_q + 32'd1;
        if (pkt_err_now && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 32'd1;
        pkt_err_d = 1'b0;
        mid_pkt_d = 1'b0;
      end else begin
        pkt_err_d = pkt_err_now;
        mid_pkt_d = 1'b1;
      end
    end

    // Normal completion has priority over the timeout. The timeout also needs
    // an empty pipeline, so in practice the two cannot coincide.
    if (state_q != ST_DONE) begin
      if (last_done) begin
        state_d = ST_DONE;
      end else if (timeout) begin
        state_d = ST_DONE;
        if (mid_pkt_q) begin
          part_err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 32'd1;
        end
      end else if ((state_q == ST_IDLE) && s_axis_tvalid) begin
        state_d = ST_RUN;
      end
    end

    // The verdict is taken from the counters as they stand once DONE is entered.
    if ((state_q == ST_DONE) && !resv_q) begin
      resv_d = 1'b1;
      res_d  = (pkt_cnt_q == 32'(NUM_PKTS)) && (err_cnt_q == '0) && !part_err_q;
    end
  end

`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
  always_comb begin
    fe_pkt_d  = fe_pkt_q;
    fe_beat_d = fe_beat_q;
    fe_vld_d  = fe_vld_q;
    if (upd && s3_err_q && !fe_vld_q) begin
      fe_pkt_d  = s3_pkt_q;
      fe_beat_d = s3_beat_q;
      fe_vld_d  = 1'b1;
    end
  end
`endif

  // datapath registers, qualified by vld_q
  always_ff @(posedge rx_clk) begin
    s1_data_q  <= s_axis_tdata;
    s1_keep_q  <= s_axis_tkeep;
    s1_last_q  <= s_axis_tlast;
    s1_base_q  <= pkt_idx_q[7:0] + byte_off_q;
    s2_err_q   <= beat_err;
    s2_last_q  <= s1_last_q;
    s2_keep_q  <= s1_keep_q;
    s3_err_q   <= s2_err_q;
    s3_last_q  <= s2_last_q;
    s3_bytes_q <= s2_pop;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
    s1_pkt_q   <= pkt_idx_q;
    s1_beat_q  <= beat_idx_q;
    s2_pkt_q   <= s1_pkt_q;
    s2_beat_q  <= s1_beat_q;
    s3_pkt_q   <= s2_pkt_q;
    s3_beat_q  <= s2_beat_q;
`endif
  end

  always_ff @(posedge rx_clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      vld_q      <= '0;
      pkt_idx_q  <= '0;
      byte_off_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      byte_cnt_q <= '0;
      pkt_err_q  <= 1'b0;
      mid_pkt_q  <= 1'b0;
      part_err_q <= 1'b0;
      res_q      <= 1'b0;
      resv_q     <= 1'b0;
      idle_cnt_q <= '0;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
      beat_idx_q <= '0;
      fe_pkt_q   <= '0;
      fe_beat_q  <= '0;
      fe_vld_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      vld_q      <= {vld_q[1:0], accept};
      pkt_idx_q  <= pkt_idx_d;
      byte_off_q <= byte_off_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pkt_err_q  <= pkt_err_d;
      mid_pkt_q  <= mid_pkt_d;
      part_err_q <= part_err_d;
      res_q      <= res_d;
      resv_q     <= resv_d;
      idle_cnt_q <= idle_cnt_d;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
      beat_idx_q <= beat_idx_d;
      fe_pkt_q   <= fe_pkt_d;
      fe_beat_q  <= fe_beat_d;
      fe_vld_q   <= fe_vld_d;
`endif
    end
  end

  assign pkt_cnt            = pkt_cnt_q;
  assign err_cnt            = err_cnt_q;
  assign byte_cnt           = byte_cnt_q;
  assign check_result       = res_q;
  assign check_result_valid = resv_q;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
  assign first_err_pkt      = fe_pkt_q;
  assign first_err_beat     = fe_beat_q;
  assign first_err_valid    = fe_vld_q;
`endif

endmodule

// File: tb/tb_axis_pattern_checker.sv
module tb_axis_pattern_checker;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int NP  = 4;
  localparam int ITO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast, tvalid, send_done;
  logic [31:0]   pkt_cnt, err_cnt;
  logic [47:0]   byte_cnt;
  logic          res, res_vld;
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
  logic [31:0]   fe_pkt;
  logic [15:0]   fe_beat;
  logic [0:0]    fe_vld;
`endif

  always #5 clk = ~clk;

  axis_pattern_checker #(.DWIDTH(DW), .NUM_PKTS(NP), .IDLE_TIMEOUT(ITO)) dut (
    .rx_clk             (clk),
    .rst                (rst),
    .s_axis_tdata       (tdata),
    .s_axis_tkeep       (tkeep),
    .s_axis_tlast       (tlast),
    .s_axis_tvalid      (tvalid),
    .remote_send_done   (send_done),
    .pkt_cnt            (pkt_cnt),
    .err_cnt            (err_cnt),
    .byte_cnt           (byte_cnt),
    .check_result       (res),
    .check_result_valid (res_vld)
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
    ,
    .first_err_pkt      (fe_pkt),
    .first_err_beat     (fe_beat),
    .first_err_valid    (fe_vld)
`endif
  );

  typedef struct {
    int          nbeats;
    logic [63:0] last_keep;
    int          flip_beat;
    int          flip_lane;
    int          short_beat;
    bit          exp_err;
    int          exp_bytes;
  } pkt_vec_t;

  typedef struct {
    int exp_pkts;
    int exp_errs;
    int exp_bytes;
    bit exp_res;
  } grp_t;

  typedef struct {
    bit err;
    int bytes;
  } sb_t;

  pkt_vec_t vecs[12];
  grp_t     grps[3];
  sb_t      exp_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       tb_pidx  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int pidx, input int boff);
    logic [DW-1:0] d;
    for (int l = 0; l < KW; l++) d[l*8 +: 8] = 8'(pidx + boff + l);
    return d;
  endfunction

  task automatic send_pkt(input pkt_vec_t v, input bit push);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    for (int b = 0; b < v.nbeats; b++) begin
      d = pat(tb_pidx, b * KW);
      k = '1;
      if (b == v.nbeats - 1) k = v.last_keep;
      if (b == v.short_beat) k = {1'b0, {(KW-1){1'b1}}};
      if (b == v.flip_beat) d[v.flip_lane*8 +: 8] = d[v.flip_lane*8 +: 8] + 8'd1;
      tdata  = d;
      tkeep  = k;
      tlast  = (b == v.nbeats - 1);
      tvalid = 1'b1;
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tb_pidx++;
    if (push) exp_q.push_back('{err: v.exp_err, bytes: v.exp_bytes});
  endtask

  task automatic do_reset();
    rst = 1'b1; tvalid = 1'b0; tlast = 1'b0; send_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tb_pidx = 0;
  endtask

  task automatic wait_verdict(output int n);
    n = 0;
    while (!res_vld && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("verdict_valid", 64'(res_vld), 64'd1);
  endtask

  // Scoreboard: one record per packet; popped each time pkt_cnt advances.
  int  m_pkts = 0;
  int  m_errs = 0;
  int  m_bytes = 0;
  sb_t e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pkts = 0; m_errs = 0; m_bytes = 0;
    end else if (pkt_cnt != 32'(m_pkts)) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected_pkt: pkt_cnt %0d with no expected packet", pkt_cnt);
        m_pkts = int'(pkt_cnt);
      end else begin
        e = exp_q.pop_front();
        m_pkts++;
        m_errs  += int'(e.err);
        m_bytes += e.bytes;
        chk("sb_pkt_cnt",  64'(pkt_cnt),  64'(m_pkts));
        chk("sb_err_cnt",  64'(err_cnt),  64'(m_errs));
        chk("sb_byte_cnt", 64'(byte_cnt), 64'(m_bytes));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] full;
    full = '1;
    for (int i = 0; i < 12; i++)
      vecs[i] = '{nbeats: 3, last_keep: full, flip_beat: -1, flip_lane: 0,
                  short_beat: -1, exp_err: 1'b0, exp_bytes: 192};
    // group 1: packet 2, beat 1, lane 5 off by one
    vecs[6].flip_beat = 1; vecs[6].flip_lane = 5; vecs[6].exp_err = 1'b1;
    // group 2: keep framing cases
    vecs[8].last_keep  = 64'h0F; vecs[8].exp_bytes = 132;
    vecs[9].last_keep  = 64'hF0; vecs[9].exp_bytes = 132; vecs[9].exp_err = 1'b1;
    vecs[10].short_beat = 1;     vecs[10].exp_bytes = 191; vecs[10].exp_err = 1'b1;
    grps[0] = '{exp_pkts: 4, exp_errs: 0, exp_bytes: 768, exp_res: 1'b1};
    grps[1] = '{exp_pkts: 4, exp_errs: 1, exp_bytes: 768, exp_res: 1'b0};
    grps[2] = '{exp_pkts: 4, exp_errs: 2, exp_bytes: 647, exp_res: 1'b0};

    tdata = '0; tkeep = '0;
    do_reset();
    chk("rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("rst_err_cnt",  64'(err_cnt),  64'd0);
    chk("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    chk("rst_res",      64'(res),      64'd0);
    chk("rst_res_vld",  64'(res_vld),  64'd0);

    for (int g = 0; g < 3; g++) begin
      if (g != 0) do_reset();
      for (int p = 0; p < 4; p++) send_pkt(vecs[g*4 + p], 1'b1);
      wait_verdict(n);
      if (g == 0) chk("verdict_latency", 64'(n), 64'd4);
      chk("grp_pkt_cnt",  64'(pkt_cnt),  64'(grps[g].exp_pkts));
      chk("grp_err_cnt",  64'(err_cnt),  64'(grps[g].exp_errs));
      chk("grp_byte_cnt", 64'(byte_cnt), 64'(grps[g].exp_bytes));
      chk("grp_result",   64'(res),      64'(grps[g].exp_res));
      chk("grp_sb_drain", 64'(exp_q.size()), 64'd0);
`ifdef AXIS_CHECKER_ERR_CAPTURE_EN
      if (g == 1) begin
        chk("cap_valid", 64'(fe_vld),  64'd1);
        chk("cap_pkt",   64'(fe_pkt),  64'd2);
        chk("cap_beat",  64'(fe_beat), 64'd1);
      end
`endif
    end

    // Idle timeout: 2 full packets then one beat of a 3rd, then silence.
    do_reset();
    send_done = 1'b1;
    send_pkt(vecs[0], 1'b1);
    send_pkt(vecs[1], 1'b1);
    tdata = pat(tb_pidx, 0); tkeep = '1; tlast = 1'b0; tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid = 1'b0;
    wait_verdict(n);
    // 3 cycles to drain, 16 idle cycles, then 1 cycle to register the verdict.
    chk("to_latency", 64'(n),        64'd20);
    chk("to_pkt_cnt", 64'(pkt_cnt),  64'd2);
    chk("to_err_cnt", 64'(err_cnt),  64'd1);
    chk("to_bytes",   64'(byte_cnt), 64'd448);
    chk("to_result",  64'(res),      64'd0);

    // Reset mid-packet, then 4 clean packets, then traffic after DONE.
    do_reset();
    for (int b = 0; b < 2; b++) begin
      tdata = pat(0, b * KW); tkeep = '1; tlast = 1'b0; tvalid = 1'b1;
      @(posedge clk); #1;
    end
    do_reset();
    chk("mid_rst_pkt_cnt",  64'(pkt_cnt),  64'd0);
    chk("mid_rst_byte_cnt", 64'(byte_cnt), 64'd0);
    for (int p = 0; p < 4; p++) send_pkt(vecs[p], 1'b1);
    wait_verdict(n);
    chk("mid_rst_result",   64'(res),      64'd1);
    chk("mid_rst_err_cnt",  64'(err_cnt),  64'd0);
    send_pkt(vecs[0], 1'b0);
    send_pkt(vecs[9], 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("done_pkt_cnt",  64'(pkt_cnt),  64'd4);
    chk("done_err_cnt",  64'(err_cnt),  64'd0);
    chk("done_byte_cnt", 64'(byte_cnt), 64'd768);
    chk("done_res_vld",  64'(res_vld),  64'd1);
    chk("done_result",   64'(res),      64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
